// File: rtl/rgb_pwm_sequencer.sv
// Three-channel PWM with a red->green->blue colour-wheel fade for the RGB LED driver.
// Define RGB_GAMMA_EN to apply a square-law correction when active duties are loaded.
module rgb_pwm_sequencer #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pwm_red,
  output logic       pwm_green,
  output logic       pwm_blue,
  output logic [1:0] phase,
  output logic       period_start
);

  localparam logic [PWM_BITS-1:0] FS    = '1;
  localparam logic [PWM_BITS-1:0] FS_M1 = FS - 1'b1;
  localparam logic [PWM_BITS-1:0] ZERO  = '0;

  localparam int                 PRESC_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);

  localparam logic [1:0] PH_R2G = 2'd0;
  localparam logic [1:0] PH_G2B = 2'd1;
  localparam logic [1:0] PH_B2R = 2'd2;
  localparam logic [1:0] PH_BAD = 2'd3;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] tgt_r;
  logic [PWM_BITS-1:0] tgt_g;
  logic [PWM_BITS-1:0] tgt_b;
  logic [PWM_BITS-1:0] act_r;
  logic [PWM_BITS-1:0] act_g;
  logic [PWM_BITS-1:0] act_b;
  logic                boundary;
  logic                step;

  function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] v);
    return (v == FS) ? FS : v + 1'b1;
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
    return (v == ZERO) ? ZERO : v - 1'b1;
  endfunction

`ifdef RGB_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] load_duty(input logic [PWM_BITS-1:0] t);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, t} * {{PWM_BITS{1'b0}}, t};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`else
  function automatic logic [PWM_BITS-1:0] load_duty(input logic [PWM_BITS-1:0] t);
    return t;
  endfunction
`endif

  assign boundary = (pwm_cnt == FS);
  assign step     = en & (presc == PRESC_LAST);

  // Period timebase: free-running regardless of en
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 1'b1;
      period_start <= boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Fade stage: targets move one LSB per step; saturation keeps the channels from wrapping
  always_ff @(posedge clk) begin
    if (rst || phase == PH_BAD) begin
      phase <= PH_R2G;
      tgt_r <= FS;
      tgt_g <= ZERO;
      tgt_b <= ZERO;
    end else if (step) begin
      case (phase)
        PH_R2G: begin
          tgt_r <= sat_dec(tgt_r);
          tgt_g <= sat_inc(tgt_g);
          if (tgt_g >= FS_M1) phase <= PH_G2B;
        end
        PH_G2B: begin
          tgt_g <= sat_dec(tgt_g);
          tgt_b <= sat_inc(tgt_b);
          if (tgt_b >= FS_M1) phase <= PH_B2R;
        end
        PH_B2R: begin
          tgt_b <= sat_dec(tgt_b);
          tgt_r <= sat_inc(tgt_r);
          if (tgt_r >= FS_M1) phase <= PH_R2G;
        end
        default: begin
        end
      endcase
    end
  end

  // Duty stage: loaded only at the period boundary so a period never sees two duties
  always_ff @(posedge clk) begin
    if (rst) begin
      act_r <= '0;
      act_g <= '0;
      act_b <= '0;
    end else if (boundary) begin
      act_r <= load_duty(tgt_r);
      act_g <= load_duty(tgt_g);
      act_b <= load_duty(tgt_b);
    end
  end

  // Output stage: one cycle behind the counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_red   <= 1'b0;
      pwm_green <= 1'b0;
      pwm_blue  <= 1'b0;
    end else begin
      pwm_red   <= en & (pwm_cnt < act_r);
      pwm_green <= en & (pwm_cnt < act_g);
      pwm_blue  <= en & (pwm_cnt < act_b);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer: reset, fade, step/boundary collision, en gating,
// mid-run reset and duty loading, with expected values worked out by hand.
module tb_rgb_pwm_sequencer;

`ifdef RGB_GAMMA_EN
  localparam int GAMMA = 1;
`else
  localparam int GAMMA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, red_a, green_a, blue_a, ps_a;
  logic rst_b, en_b, red_b, green_b, blue_b, ps_b;
  logic rst_c, en_c, red_c, green_c, blue_c, ps_c;
  logic rst_g, en_g, red_g, green_g, blue_g, ps_g;
  logic [1:0] ph_a, ph_b, ph_c, ph_g;

  int vectors = 0;
  int miscompares = 0;

  rgb_pwm_sequencer #(.PWM_BITS(4), .STEP_CYCLES(1000)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pwm_red(red_a), .pwm_green(green_a),
    .pwm_blue(blue_a), .phase(ph_a), .period_start(ps_a));

  rgb_pwm_sequencer #(.PWM_BITS(4), .STEP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pwm_red(red_b), .pwm_green(green_b),
    .pwm_blue(blue_b), .phase(ph_b), .period_start(ps_b));

  rgb_pwm_sequencer #(.PWM_BITS(4), .STEP_CYCLES(16)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .pwm_red(red_c), .pwm_green(green_c),
    .pwm_blue(blue_c), .phase(ph_c), .period_start(ps_c));

  rgb_pwm_sequencer #(.PWM_BITS(8), .STEP_CYCLES(2)) dut_g (
    .clk(clk), .rst(rst_g), .en(en_g), .pwm_red(red_g), .pwm_green(green_g),
    .pwm_blue(blue_g), .phase(ph_g), .period_start(ps_g));

  // Duty loaded from a target: linear, or square-law when the correction is built in
  function automatic int exp_act(input int t, input int bits);
    return (GAMMA != 0) ? ((t * t) >> bits) : t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    rst_a = 1'b1; en_a = 1'b1;
    tick();
    vectors++;
    if ({red_a, green_a, blue_a, ps_a, ph_a} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000000", {red_a, green_a, blue_a, ps_a, ph_a});
    end
    vectors++;
    if (dut_a.tgt_r !== 4'd15 || dut_a.tgt_g !== 4'd0 || dut_a.act_r !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_regs: tgt_r %0d tgt_g %0d act_r %0d expected 15 0 0",
               dut_a.tgt_r, dut_a.tgt_g, dut_a.act_r);
    end
    rst_a = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      exp_v[3] = (e > 16) && (((e - 1) % 16) < exp_act(15, 4));
      exp_v[2] = 1'b0;
      exp_v[1] = 1'b0;
      exp_v[0] = (e % 16 == 0);
      vectors++;
      if ({red_a, green_a, blue_a, ps_a} !== exp_v) begin
        miscompares++;
        $display("FAIL first_period cycle %0d: got %b expected %b", e,
                 {red_a, green_a, blue_a, ps_a}, exp_v);
      end
    end
  endtask

  task automatic test_fade();
    logic [1:0] exp_ph;
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      exp_ph = (e < 30) ? 2'd0 : (e < 60) ? 2'd1 : (e < 90) ? 2'd2 : 2'd0;
      vectors++;
      if (ph_b !== exp_ph) begin
        miscompares++;
        $display("FAIL fade_phase cycle %0d: got %0d expected %0d", e, ph_b, exp_ph);
      end
      if (e <= 30) begin
        vectors++;
        if (int'(dut_b.tgt_g) != e / 2 || int'(dut_b.tgt_r) + int'(dut_b.tgt_g) != 15 ||
            dut_b.tgt_b !== 4'd0) begin
          miscompares++;
          $display("FAIL fade_r2g cycle %0d: r %0d g %0d b %0d expected r %0d g %0d b 0",
                   e, dut_b.tgt_r, dut_b.tgt_g, dut_b.tgt_b, 15 - e / 2, e / 2);
        end
      end
      if (e == 60 || e == 90) begin
        vectors++;
        if ((e == 60 && (dut_b.tgt_g !== 4'd0 || dut_b.tgt_b !== 4'd15)) ||
            (e == 90 && (dut_b.tgt_b !== 4'd0 || dut_b.tgt_r !== 4'd15))) begin
          miscompares++;
          $display("FAIL fade_handover cycle %0d: r %0d g %0d b %0d", e,
                   dut_b.tgt_r, dut_b.tgt_g, dut_b.tgt_b);
        end
      end
    end
  endtask

  task automatic test_collision();
    int cr[4];
    int cg[4];
    for (int p = 0; p < 4; p++) begin
      cr[p] = 0; cg[p] = 0;
    end
    rst_c = 1'b1; en_c = 1'b1;
    tick();
    rst_c = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e >= 17) begin
        cr[(e - 1) / 16] += int'(red_c);
        cg[(e - 1) / 16] += int'(green_c);
      end
      if (e == 16) begin
        vectors++;
        if (int'(dut_c.act_r) != exp_act(15, 4) || dut_c.tgt_r !== 4'd14 || ps_c !== 1'b1) begin
          miscompares++;
          $display("FAIL collision_edge: act_r %0d tgt_r %0d ps %0d expected %0d 14 1",
                   dut_c.act_r, dut_c.tgt_r, ps_c, exp_act(15, 4));
        end
      end
    end
    for (int p = 1; p <= 3; p++) begin
      vectors++;
      if (cr[p] != exp_act(16 - p, 4) || cg[p] != exp_act(p - 1, 4)) begin
        miscompares++;
        $display("FAIL collision_period %0d: red %0d green %0d expected %0d %0d", p,
                 cr[p], cg[p], exp_act(16 - p, 4), exp_act(p - 1, 4));
      end
    end
    vectors++;
    if (blue_c !== 1'b0 || ph_c !== 2'd0) begin
      miscompares++;
      $display("FAIL collision_other: blue %0d phase %0d expected 0 0", blue_c, ph_c);
    end
  endtask

  task automatic test_en_gating();
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int e = 1; e <= 20; e++) tick();
    vectors++;
    if (red_b !== (3 < exp_act(8, 4)) || green_b !== (3 < exp_act(7, 4)) ||
        dut_b.tgt_g !== 4'd10) begin
      miscompares++;
      $display("FAIL en_before: red %0d green %0d tgt_g %0d expected %0d %0d 10",
               red_b, green_b, dut_b.tgt_g, 3 < exp_act(8, 4), 3 < exp_act(7, 4));
    end
    en_b = 1'b0;
    for (int e = 21; e <= 57; e++) begin
      tick();
      vectors++;
      if ({red_b, green_b, blue_b, ph_b, dut_b.tgt_g, dut_b.presc} !== {3'b000, 2'd0, 4'd10, 1'b0}) begin
        miscompares++;
        $display("FAIL en_frozen cycle %0d: rgb %b phase %0d tgt_g %0d presc %0d expected 000 0 10 0",
                 e, {red_b, green_b, blue_b}, ph_b, dut_b.tgt_g, dut_b.presc);
      end
    end
    vectors++;
    if (int'(dut_b.act_r) != exp_act(5, 4) || int'(dut_b.act_g) != exp_act(10, 4)) begin
      miscompares++;
      $display("FAIL en_act_update: act_r %0d act_g %0d expected %0d %0d",
               dut_b.act_r, dut_b.act_g, exp_act(5, 4), exp_act(10, 4));
    end
    en_b = 1'b1;
    for (int e = 58; e <= 67; e++) begin
      tick();
      vectors++;
      if (ph_b !== ((e >= 67) ? 2'd1 : 2'd0)) begin
        miscompares++;
        $display("FAIL en_resume cycle %0d: phase %0d expected %0d", e, ph_b, (e >= 67) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_v;
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int e = 1; e <= 49; e++) tick();
    vectors++;
    if ({red_b, green_b, blue_b, ph_b} !== {3'b011, 2'd1}) begin
      miscompares++;
      $display("FAIL mid_before: rgb %b phase %0d expected 011 1", {red_b, green_b, blue_b}, ph_b);
    end
    rst_b = 1'b1;
    tick();
    vectors++;
    if ({red_b, green_b, blue_b, ps_b, ph_b} !== 6'b0 || dut_b.tgt_r !== 4'd15) begin
      miscompares++;
      $display("FAIL mid_reset: outputs %b tgt_r %0d expected 000000 15",
               {red_b, green_b, blue_b, ps_b, ph_b}, dut_b.tgt_r);
    end
    rst_b = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      exp_v[3] = (e > 16) && (((e - 1) % 16) < exp_act(8, 4));
      exp_v[2] = (e > 16) && (((e - 1) % 16) < exp_act(7, 4));
      exp_v[1] = 1'b0;
      exp_v[0] = (e % 16 == 0);
      vectors++;
      if ({red_b, green_b, blue_b, ps_b} !== exp_v) begin
        miscompares++;
        $display("FAIL mid_restart cycle %0d: got %b expected %b", e,
                 {red_b, green_b, blue_b, ps_b}, exp_v);
      end
    end
  endtask

  task automatic test_gamma();
    int nr, ng, nb;
    nr = 0; ng = 0; nb = 0;
    rst_g = 1'b1; en_g = 1'b1;
    tick();
    rst_g = 1'b0;
    for (int e = 1; e <= 512; e++) begin
      tick();
      if (e == 256) begin
        vectors++;
        if (int'(dut_g.act_r) != exp_act(128, 8) || ph_g !== 2'd0 || ps_g !== 1'b1) begin
          miscompares++;
          $display("FAIL duty_load: act_r %0d phase %0d ps %0d expected %0d 0 1",
                   dut_g.act_r, ph_g, ps_g, exp_act(128, 8));
        end
      end
      if (e >= 257) begin
        nr += int'(red_g);
        ng += int'(green_g);
        nb += int'(blue_g);
      end
    end
    vectors++;
    if (nr != exp_act(128, 8) || ng != exp_act(127, 8) || nb != 0) begin
      miscompares++;
      $display("FAIL duty_counts: red %0d green %0d blue %0d expected %0d %0d 0",
               nr, ng, nb, exp_act(128, 8), exp_act(127, 8));
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    rst_c = 1'b1; en_c = 1'b1;
    rst_g = 1'b1; en_g = 1'b1;
    test_reset();
    test_fade();
    test_collision();
    test_en_gating();
    test_reset_mid();
    test_gamma();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_sequencer.md
Name: rgb_pwm_sequencer

Overview:
- Generates the three PWM drive signals that feed the RGB LED current-driver primitive.
- Replaces raw counter-bit decoding with per-channel duty-cycle PWM and a smooth colour-wheel fade: red to green to blue to red, repeating.
- Runs on the internal high-frequency oscillator clock. Sits directly upstream of the LED driver instance in the top level.

Parameters:
- PWM_BITS, 8: width of the PWM counter and of each duty value. Full scale FS = 2^PWM_BITS - 1.
- STEP_CYCLES, 48000: clock cycles per fade step. Must be >= 1.

Ports:
- clk  input  1  oscillator clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable. Low forces PWM outputs low and freezes the fade.
- pwm_red  output  1  red PWM, to driver RGB2PWM.
- pwm_green  output  1  green PWM, to driver RGB0PWM.
- pwm_blue  output  1  blue PWM, to driver RGB1PWM.
- phase  output  2  current fade phase: 0=R2G, 1=G2B, 2=B2R.
- period_start  output  1  one-cycle pulse when a new PWM period begins.

Behaviour:
- Reset (rst high at clk edge):
  - pwm_cnt=0, presc=0, phase=R2G.
  - Target duties: tgt_r=FS, tgt_g=0, tgt_b=0.
  - Active duties act_r/g/b=0.
  - All outputs 0. rst overrides en.
- PWM counter:
  - pwm_cnt increments every cycle regardless of en and wraps FS to 0.
  - Boundary cycle = pwm_cnt==FS. On that edge act_x <= tgt_x, using the pre-edge register values.
  - period_start is registered and is 1 in the cycle where pwm_cnt==0.
- Outputs are registered: pwm_x <= en & (pwm_cnt < act_x).
  - Latency from pwm_cnt value to output: 1 cycle.
  - act_x=0 means constantly low. act_x=FS means high FS of every 2^PWM_BITS cycles.
- Prescaler:
  - When en=1, presc counts 0..STEP_CYCLES-1 and wraps.
  - step = en & (presc==STEP_CYCLES-1).
  - When en=0, presc holds.
- Fade FSM, advances only on step:
  - R2G: tgt_r--, tgt_g++. When tgt_g reaches FS (the same step that writes FS), next phase = G2B.
  - G2B: tgt_g--, tgt_b++. Leaves to B2R when tgt_b reaches FS.
  - B2R: tgt_b--, tgt_r++. Leaves to R2G when tgt_r reaches FS.
  - Phase value 3 is illegal. If reached, go to R2G with tgt_r=FS, tgt_g=0, tgt_b=0 on the next cycle.
- Invariants:
  - The rising channel plus the falling channel always equals FS.
  - The third channel is 0.
  - No channel wraps: arithmetic is PWM_BITS wide and must never underflow or overflow.
- Phase length and full wheel:
  - Each phase lasts exactly FS steps.
  - A full wheel takes 3*FS*STEP_CYCLES enabled cycles.
- Simultaneous step and boundary: act_x captures the old tgt_x. The new tgt_x is taken at the next boundary. Active duties change only at boundaries, so output is glitch-free.
- en deassert mid-period:
  - Outputs go 0 on the next edge.
  - act_x keeps updating at boundaries.
  - On re-assert, the fade resumes from the held tgt and presc.
- rst mid-period: restarts everything; no partial period is carried over.

Optional Feature:
- RGB_GAMMA_EN defined:
  - At each boundary load, act_x <= (tgt_x * tgt_x) >> PWM_BITS. This is a square-law perceptual correction.
  - The product is computed 2*PWM_BITS wide, so there is no overflow.
  - Example for PWM_BITS=8: tgt 255 gives act 254; tgt 128 gives act 64.
- RGB_GAMMA_EN undefined: act_x <= tgt_x (linear). No multiplier is present.

Test Plan:
- Reset/first period (PWM_BITS=4, STEP_CYCLES=1000, en=1):
  - All outputs 0 for cycles 1..16 after reset release.
  - From the 17th cycle, pwm_red is high 15 of every 16 cycles; green and blue stay 0.
  - period_start pulses every 16 cycles.
- Fade sequencing (PWM_BITS=4, STEP_CYCLES=2):
  - phase goes 0 to 1 after exactly 30 cycles, 1 to 2 after 60, and back to 0 after 90.
  - tgt_r+tgt_g=15 throughout R2G, with tgt_b=0.
- Boundary/step collision:
  - Force a step on the cycle where pwm_cnt==FS.
  - act_x holds the pre-step target for the whole next period; the new value appears one period later.
- en gating:
  - Drop en for 37 cycles mid-R2G. All PWM outputs are 0 within 1 cycle, and phase, presc and tgt are frozen.
  - After re-assert, the remaining steps to G2B are unchanged.
- Reset mid-operation:
  - Assert rst during G2B with outputs high.
  - Next cycle: outputs 0 and phase=0. After release, the first-period behaviour matches the first test.
- RGB_GAMMA_EN (PWM_BITS=8): with tgt_r=128 loaded, pwm_red is high 64 of every 256 cycles. Without the macro it is high 128 of every 256.
